// File: rtl/tdc_event_reader.sv
// tdc_event_reader: captures TDC channel events into a first-word-fall-through FIFO and streams them out.
// Optional build macro TDC_READER_DROP_EN: discard events on a full FIFO instead of stalling the TDC.
module tdc_event_reader #(
    parameter int unsigned DEPTH         = 8,
    parameter logic [3:0]  CHANNEL_ID    = 4'd0,
    parameter int unsigned CLEAR_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tdc_hasEvent,
    input  logic [31:0]              tdc_timestamp,
    input  logic [31:0]              tdc_timeOverThreshold,
    output logic                     tdc_clear,
    input  logic                     sw_flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic [3:0]               out_channel,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     clear_err,
    output logic [15:0]              drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_DROP} state_t;

    state_t        state;
    logic [7:0]    timer;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          event_seen;
    logic          capture;
    logic          pop;

    // Capture decisions use the registered count, so a same-cycle pop never frees space for it.
    assign full       = (fifo_count == (AW+1)'(DEPTH));
    assign event_seen = (state == IDLE) && tdc_hasEvent && !sw_flush;
    assign capture    = event_seen && !full;
    assign pop        = out_valid && out_ready;

    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign out_channel = CHANNEL_ID;

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= {tdc_timestamp, tdc_timeOverThreshold};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (sw_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tdc_clear <= 1'b0;
            timer     <= '0;
            clear_err <= 1'b0;
        end else begin
            tdc_clear <= 1'b0;
            case (state)
                IDLE: begin
`ifdef TDC_READER_DROP_EN
                    if (event_seen) begin
`else
                    if (capture) begin
`endif
                        state     <= ACK;
                        tdc_clear <= 1'b1;
                    end
                end
                ACK: begin
                    timer <= 8'(CLEAR_TIMEOUT);
                    state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    // Timeout fires on the edge the counter reaches 0, giving a reissue CLEAR_TIMEOUT+1 cycles later.
                    if (!tdc_hasEvent) begin
                        state <= IDLE;
                    end else if (timer <= 8'd1) begin
                        timer     <= '0;
                        clear_err <= 1'b1;
                        tdc_clear <= 1'b1;
                        state     <= ACK;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TDC_READER_DROP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (event_seen && full && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_tdc_event_reader.sv
// Directed self-checking bench for tdc_event_reader (DEPTH=8, CLEAR_TIMEOUT=15, CHANNEL_ID=0xA).
module tb_tdc_event_reader;
    logic        clk;
    logic        reset;
    logic        tdc_hasEvent;
    logic [31:0] tdc_timestamp;
    logic [31:0] tdc_timeOverThreshold;
    logic        tdc_clear;
    logic        sw_flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_channel;
    logic [3:0]  fifo_count;
    logic        clear_err;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    tdc_event_reader #(
        .DEPTH(8),
        .CHANNEL_ID(4'hA),
        .CLEAR_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tdc_hasEvent(tdc_hasEvent),
        .tdc_timestamp(tdc_timestamp),
        .tdc_timeOverThreshold(tdc_timeOverThreshold),
        .tdc_clear(tdc_clear),
        .sw_flush(sw_flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_channel(out_channel),
        .fifo_count(fifo_count),
        .clear_err(clear_err),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TDC model: hold the event until the clear is seen, drop it, then let the FSM return to IDLE.
    task automatic tdc_event(input logic [31:0] ts, input logic [31:0] tot);
        bit seen = 1'b0;
        tdc_timestamp         = ts;
        tdc_timeOverThreshold = tot;
        tdc_hasEvent          = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (tdc_clear) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL clear_handshake got=0 exp=1 ts=%h", ts); end
        tdc_hasEvent = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b exp=0", tdc_clear); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", clear_err); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        total++; if (out_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (out_channel !== 4'hA) begin bad++; $display("FAIL channel got=%h exp=a", out_channel); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        out_ready             = 1'b1;
        tdc_timestamp         = 32'h0000_1234;
        tdc_timeOverThreshold = 32'h0000_0056;
        tdc_hasEvent          = 1'b1;
        @(posedge clk); #1;
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 64'h0000_1234_0000_0056) begin bad++; $display("FAIL single_data got=%h exp=0000123400000056", out_data); end
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL single_clear got=%b exp=1", tdc_clear); end
        tdc_hasEvent = 1'b0;
        @(posedge clk); #1;
        total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL single_clear_len got=%b exp=0", tdc_clear); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL single_pop got=%0d exp=0", fifo_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_fill;
        logic [63:0] exp;
        int first;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tdc_event(32'h1000_0000 + 32'(i), 32'h0000_2000 + 32'(i));
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", fifo_count); end
        total++; if (out_data !== 64'h1000_0000_0000_2000) begin bad++; $display("FAIL fill_head got=%h exp=1000000000002000", out_data); end
`ifdef TDC_READER_DROP_EN
        tdc_event(32'h1000_0008, 32'h0000_2008);
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL drop_fifo got=%0d exp=8", fifo_count); end
        first = 0;
`else
        tdc_timestamp         = 32'h1000_0008;
        tdc_timeOverThreshold = 32'h0000_2008;
        tdc_hasEvent          = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL full_stall got=%b exp=0 cyc=%0d", tdc_clear, c); end
        end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", fifo_count); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (fifo_count !== 4'd7) begin bad++; $display("FAIL full_pop got=%0d exp=7", fifo_count); end
        total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL full_pop_noclear got=%b exp=0", tdc_clear); end
        total++; if (out_data !== 64'h1000_0001_0000_2001) begin bad++; $display("FAIL full_pop_head got=%h exp=1000000100002001", out_data); end
        @(posedge clk); #1;
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_capture got=%0d exp=8", fifo_count); end
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL full_clear got=%b exp=1", tdc_clear); end
        tdc_hasEvent = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        first = 1;
`endif
        for (int i = first; i < first + 8; i++) begin
            exp = {32'h1000_0000 + 32'(i), 32'h0000_2000 + 32'(i)};
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL fill_drain got=%b/%h exp=1/%h", out_valid, out_data, exp); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL fill_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_wrap;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) tdc_event(32'hA000_0000 + 32'(i), 32'h0000_0100 + 32'(i));
            end
            begin
                int idx = 0;
                logic [63:0] exp;
                for (int c = 0; c < 3000 && idx < 20; c++) begin
                    out_ready = ~out_ready;
                    if (out_valid && out_ready) begin
                        exp = {32'hA000_0000 + 32'(idx), 32'h0000_0100 + 32'(idx)};
                        total++; if (out_data !== exp) begin bad++; $display("FAIL wrap_data got=%h exp=%h", out_data, exp); end
                        idx++;
                    end
                    total++; if (fifo_count > 4'd8) begin bad++; $display("FAIL wrap_count got=%0d exp<=8", fifo_count); end
                    @(posedge clk); #1;
                end
                total++; if (idx != 20) begin bad++; $display("FAIL wrap_timeout got=%0d exp=20", idx); end
                out_ready = 1'b0;
            end
        join
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tdc_event(32'hB000_0000 + 32'(i), 32'h0000_00C0 + 32'(i));
        total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL b2b_pre got=%0d exp=3", fifo_count); end
        tdc_timestamp         = 32'hB000_0003;
        tdc_timeOverThreshold = 32'h0000_00C3;
        tdc_hasEvent          = 1'b1;
        out_ready             = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", fifo_count); end
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL b2b_clear got=%b exp=1", tdc_clear); end
        tdc_hasEvent = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 1; i < 4; i++) begin
            exp = {32'hB000_0000 + 32'(i), 32'h0000_00C0 + 32'(i)};
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL b2b_order got=%b/%h exp=1/%h", out_valid, out_data, exp); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_stuck;
        logic exp_clr;
        out_ready             = 1'b0;
        tdc_timestamp         = 32'h5555_0000;
        tdc_timeOverThreshold = 32'h0000_0077;
        tdc_hasEvent          = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            exp_clr = (c == 1) || (c == 17) || (c == 33);
            total++; if (tdc_clear !== exp_clr) begin bad++; $display("FAIL stuck_clear got=%b exp=%b cyc=%0d", tdc_clear, exp_clr, c); end
            total++; if (clear_err !== (c >= 17)) begin bad++; $display("FAIL stuck_err got=%b exp=%b cyc=%0d", clear_err, (c >= 17), c); end
        end
        tdc_hasEvent = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL stuck_count got=%0d exp=1", fifo_count); end
        total++; if (out_data !== 64'h5555_0000_0000_0077) begin bad++; $display("FAIL stuck_data got=%h exp=5555000000000077", out_data); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) tdc_event(32'hF000_0000 + 32'(i), 32'h0000_0F00 + 32'(i));
        total++; if (fifo_count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", fifo_count); end
        sw_flush              = 1'b1;
        tdc_timestamp         = 32'hF000_0004;
        tdc_timeOverThreshold = 32'h0000_0F04;
        tdc_hasEvent          = 1'b1;
        @(posedge clk); #1;
        sw_flush = 1'b0;
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", fifo_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL flush_block got=%b exp=0", tdc_clear); end
        @(posedge clk); #1;
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL flush_recap got=%0d exp=1", fifo_count); end
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b exp=1", tdc_clear); end
        total++; if (out_data !== 64'hF000_0004_0000_0F04) begin bad++; $display("FAIL flush_data got=%h exp=f000000400000f04", out_data); end
        tdc_hasEvent = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (clear_err !== 1'b1) begin bad++; $display("FAIL flush_err_sticky got=%b exp=1", clear_err); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL flush_drain got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_mid;
        tdc_timestamp         = 32'hCAFE_0001;
        tdc_timeOverThreshold = 32'h0000_0042;
        tdc_hasEvent          = 1'b1;
        @(posedge clk); #1;
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b exp=1", tdc_clear); end
        #2 reset = 1'b1;
        #1;
        total++; if (tdc_clear !== 1'b0) begin bad++; $display("FAIL mid_clear got=%b exp=0", tdc_clear); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", clear_err); end
        total++; if (out_data !== 64'd0) begin bad++; $display("FAIL mid_data got=%h exp=0", out_data); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL mid_drop got=%0d exp=0", drop_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL mid_recap got=%0d exp=1", fifo_count); end
        total++; if (tdc_clear !== 1'b1) begin bad++; $display("FAIL mid_reclear got=%b exp=1", tdc_clear); end
        total++; if (out_data !== 64'hCAFE_0001_0000_0042) begin bad++; $display("FAIL mid_redata got=%h exp=cafe000100000042", out_data); end
        tdc_hasEvent = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset                 = 1'b1;
        tdc_hasEvent          = 1'b0;
        tdc_timestamp         = '0;
        tdc_timeOverThreshold = '0;
        sw_flush              = 1'b0;
        out_ready             = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_stuck();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
